// File: rtl/wptr_full_ctrl.sv
// Write-side pointer/status controller for the dual-clock FIFO (write clock domain).
// Optional level/almost-full logic is compiled in when WPTR_LEVEL_EN is defined.
module wptr_full_ctrl #(
   parameter int PTR_WIDTH    = 3,
   parameter int AFULL_THRESH = 6
) (
   input  logic                 wclk,
   input  logic                 wrst,
   input  logic                 w_en,
   input  logic [PTR_WIDTH:0]   g_rptr_sync,
   input  logic                 ovf_clr,
   output logic [PTR_WIDTH:0]   b_wptr,
   output logic [PTR_WIDTH:0]   g_wptr,
   output logic                 full,
   output logic                 almost_full,
   output logic [PTR_WIDTH:0]   wlevel,
   output logic                 overflow
);

   logic                w_acc;
   logic [PTR_WIDTH:0]  b_wptr_next;
   logic [PTR_WIDTH:0]  g_wptr_next;
   logic [PTR_WIDTH:0]  g_rptr_full;
   logic                full_next;

   assign w_acc       = w_en & ~full;
   assign b_wptr_next = b_wptr + {{PTR_WIDTH{1'b0}}, w_acc};
   assign g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next;

   // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
   assign g_rptr_full = {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]};
   assign full_next   = (g_wptr_next == g_rptr_full);

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         b_wptr <= '0;
         g_wptr <= '0;
         full   <= 1'b0;
      end else begin
         b_wptr <= b_wptr_next;
         g_wptr <= g_wptr_next;
         full   <= full_next;
      end
   end

   // Set has priority over clear so a rejected write is never missed.
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         overflow <= 1'b0;
      end else if (w_en & full) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

`ifdef WPTR_LEVEL_EN
   localparam logic [PTR_WIDTH:0] AFULL_VAL = AFULL_THRESH[PTR_WIDTH:0];

   logic [PTR_WIDTH:0]  b_rptr_sync;
   logic [PTR_WIDTH:0]  wlevel_next;
   logic                almost_full_next;

   always_comb begin
      b_rptr_sync            = '0;
      b_rptr_sync[PTR_WIDTH] = g_rptr_sync[PTR_WIDTH];
      for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
         b_rptr_sync[i] = b_rptr_sync[i+1] ^ g_rptr_sync[i];
      end
   end

   assign wlevel_next      = b_wptr_next - b_rptr_sync;
   assign almost_full_next = (wlevel_next >= AFULL_VAL);

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         wlevel      <= '0;
         almost_full <= 1'b0;
      end else begin
         wlevel      <= wlevel_next;
         almost_full <= almost_full_next;
      end
   end
`else
   assign wlevel      = '0;
   assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl: directed scenarios plus randomized traffic
// against a counting model (writes minus reads) of the FIFO.
module tb_wptr_full_ctrl;

   localparam int PW    = 3;
   localparam int DEPTH = 8;
   localparam int AF    = 6;

   logic          wclk;
   logic          wrst;
   logic          w_en;
   logic [PW:0]   g_rptr_sync;
   logic          ovf_clr;
   logic [PW:0]   b_wptr;
   logic [PW:0]   g_wptr;
   logic          full;
   logic          almost_full;
   logic [PW:0]   wlevel;
   logic          overflow;

   int total = 0;
   int bad   = 0;

   // Model: unbounded write/read counts; everything else derives from their difference.
   int wr_cnt, rd_cnt;
   bit m_full, m_ovf;

   wptr_full_ctrl #(.PTR_WIDTH(PW), .AFULL_THRESH(AF)) dut (
      .wclk(wclk), .wrst(wrst), .w_en(w_en), .g_rptr_sync(g_rptr_sync),
      .ovf_clr(ovf_clr), .b_wptr(b_wptr), .g_wptr(g_wptr), .full(full),
      .almost_full(almost_full), .wlevel(wlevel), .overflow(overflow)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [PW:0] to_gray(input int n);
      logic [PW:0] b;
      b = PW'(0) + (n % 16);
      return b ^ (b >> 1);
   endfunction

   function automatic int exp_level();
`ifdef WPTR_LEVEL_EN
      return wr_cnt - rd_cnt;
`else
      return 0;
`endif
   endfunction

   function automatic bit exp_af();
`ifdef WPTR_LEVEL_EN
      return (wr_cnt - rd_cnt) >= AF;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      wr_cnt = 0;
      rd_cnt = 0;
      m_full = 0;
      m_ovf  = 0;
   endtask

   // Drive one cycle from the negedge, advance the model at the posedge, return at the next negedge.
   task automatic cycle(input logic we, input logic clr);
      bit acc;
      w_en        = we;
      ovf_clr     = clr;
      g_rptr_sync = to_gray(rd_cnt);
      @(posedge wclk);
      acc = we && !m_full;
      if (we && m_full) m_ovf = 1;
      else if (clr)     m_ovf = 0;
      if (acc) wr_cnt++;
      m_full = (wr_cnt - rd_cnt) == DEPTH;
      @(negedge wclk);
   endtask

   task automatic do_reset();
      @(negedge wclk);
      wrst    = 1'b1;
      w_en    = 1'b0;
      ovf_clr = 1'b0;
      @(negedge wclk);
      wrst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      wrst = 1'b1;
      w_en = 1'b1;
      ovf_clr = 1'b0;
      g_rptr_sync = '0;
      repeat (2) @(negedge wclk);
      total++;
      if ({b_wptr, g_wptr, full, almost_full, wlevel, overflow} !== '0) begin
         bad++;
         $display("[TB] FAIL reset_hold got=%0h want=0",
                  {b_wptr, g_wptr, full, almost_full, wlevel, overflow});
      end
      wrst = 1'b0;
      model_reset();
      total++;
      if (b_wptr !== 4'd0) begin
         bad++;
         $display("[TB] FAIL reset_release got=%0d want=0", b_wptr);
      end
      cycle(1'b1, 1'b0);
      total++;
      if (b_wptr !== 4'd1) begin
         bad++;
         $display("[TB] FAIL first_write got=%0d want=1", b_wptr);
      end
      // Mid-burst asynchronous reset must clear outputs before any clock edge.
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      #2 wrst = 1'b1;
      #1;
      total++;
      if ({b_wptr, g_wptr, full, almost_full, wlevel, overflow} !== '0) begin
         bad++;
         $display("[TB] FAIL async_reset got=%0h want=0",
                  {b_wptr, g_wptr, full, almost_full, wlevel, overflow});
      end
      @(negedge wclk);
      wrst = 1'b0;
      model_reset();
   endtask

   task automatic test_fill();
      do_reset();
      rd_cnt = 0;
      for (int i = 1; i <= DEPTH; i++) begin
         cycle(1'b1, 1'b0);
         total++;
         if (b_wptr !== 4'(i)) begin
            bad++;
            $display("[TB] FAIL fill_bptr got=%0d want=%0d", b_wptr, i);
         end
         total++;
         if (full !== (i == DEPTH)) begin
            bad++;
            $display("[TB] FAIL fill_full got=%0b want=%0b at=%0d", full, i == DEPTH, i);
         end
         total++;
`ifdef WPTR_LEVEL_EN
         if (almost_full !== (i >= AF) || wlevel !== 4'(i)) begin
            bad++;
            $display("[TB] FAIL fill_level got=%0d/%0b want=%0d/%0b", wlevel, almost_full, i, i >= AF);
         end
`else
         if (almost_full !== 1'b0 || wlevel !== 4'd0) begin
            bad++;
            $display("[TB] FAIL fill_level got=%0d/%0b want=0/0", wlevel, almost_full);
         end
`endif
      end
      total++;
      if (g_wptr !== 4'b1100) begin
         bad++;
         $display("[TB] FAIL fill_gray got=%b want=1100", g_wptr);
      end
   endtask

   task automatic test_overflow();
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      total++;
      if (b_wptr !== 4'd8 || overflow !== 1'b1) begin
         bad++;
         $display("[TB] FAIL ovf_set got=%0d/%0b want=8/1", b_wptr, overflow);
      end
      cycle(1'b1, 1'b1);
      total++;
      if (overflow !== 1'b1) begin
         bad++;
         $display("[TB] FAIL ovf_set_wins got=%0b want=1", overflow);
      end
      cycle(1'b0, 1'b1);
      total++;
      if (overflow !== 1'b0) begin
         bad++;
         $display("[TB] FAIL ovf_clear got=%0b want=0", overflow);
      end
   endtask

   task automatic test_drain_view();
      rd_cnt = 3;
      cycle(1'b0, 1'b0);
      total++;
      if (full !== 1'b0) begin
         bad++;
         $display("[TB] FAIL drain_full got=%0b want=0", full);
      end
      total++;
      if (wlevel !== 4'(exp_level()) || almost_full !== exp_af() || exp_level() != 0 && wlevel !== 4'd5) begin
         bad++;
         $display("[TB] FAIL drain_level got=%0d/%0b want=%0d/%0b", wlevel, almost_full, exp_level(), exp_af());
      end
   endtask

   task automatic test_wrap();
      rd_cnt = 8;
      while (wr_cnt < 15) cycle(1'b1, 1'b0);
      rd_cnt = 9;
      cycle(1'b1, 1'b0);
      total++;
      if (b_wptr !== 4'd0 || wlevel !== 4'(exp_level()) || full !== 1'b0) begin
         bad++;
         $display("[TB] FAIL wrap_first got=%0d/%0d/%0b want=0/%0d/0", b_wptr, wlevel, full, exp_level());
      end
      cycle(1'b1, 1'b0);
      total++;
      if (b_wptr !== 4'd1 || wlevel !== 4'(exp_level()) || full !== 1'b1 || g_wptr !== 4'b0001) begin
         bad++;
         $display("[TB] FAIL wrap_second got=%0d/%0d/%0b/%b want=1/%0d/1/0001",
                  b_wptr, wlevel, full, g_wptr, exp_level());
      end
   endtask

   task automatic test_random();
      logic [PW:0] prev_g;
      int diff;
      do_reset();
      prev_g = '0;
      for (int n = 0; n < 400; n++) begin
         if (rd_cnt < wr_cnt && $urandom_range(0, 2) == 0) rd_cnt++;
         cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
         total++;
         if (b_wptr !== 4'(wr_cnt % 16) || g_wptr !== to_gray(wr_cnt)) begin
            bad++;
            $display("[TB] FAIL rand_ptr got=%0d/%b want=%0d/%b", b_wptr, g_wptr, wr_cnt % 16, to_gray(wr_cnt));
         end
         diff = $countones(g_wptr ^ prev_g);
         total++;
         if (diff > 1) begin
            bad++;
            $display("[TB] FAIL rand_gray_step got=%0d want<=1", diff);
         end
         prev_g = g_wptr;
         total++;
         if (full !== m_full || overflow !== m_ovf) begin
            bad++;
            $display("[TB] FAIL rand_flags got=%0b/%0b want=%0b/%0b", full, overflow, m_full, m_ovf);
         end
         total++;
         if (wlevel !== 4'(exp_level()) || almost_full !== exp_af()) begin
            bad++;
            $display("[TB] FAIL rand_level got=%0d/%0b want=%0d/%0b", wlevel, almost_full, exp_level(), exp_af());
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_drain_view();
      test_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Write-side pointer and status controller for the dual-clock FIFO. It lives in the write clock domain and advances the binary and Gray write pointers on accepted writes. It generates registered `full`, `almost_full`, fill level and a sticky overflow flag, using the Gray read pointer after it has been synchronized into the write domain. It pairs with the read-side pointer/empty controller; `g_wptr` is the value the top level synchronizes into the read domain.

## Interface
Parameters:
- `PTR_WIDTH`, default 3: address width; FIFO depth = 2^PTR_WIDTH; pointers are PTR_WIDTH+1 bits.
- `AFULL_THRESH`, default 6: `almost_full` asserts when the fill level is at or above this value (1 .. 2^PTR_WIDTH).

Ports:
- `wclk`  in  1  write-domain clock; all state updates on its rising edge.
- `wrst`  in  1  asynchronous, active-high reset.
- `w_en`  in  1  write request.
- `g_rptr_sync`  in  PTR_WIDTH+1  Gray read pointer, already 2-flop synchronized into `wclk` by the top level.
- `ovf_clr`  in  1  clears `overflow`.
- `b_wptr`  out  PTR_WIDTH+1  binary write pointer; the low PTR_WIDTH bits are the RAM write address.
- `g_wptr`  out  PTR_WIDTH+1  Gray write pointer, registered, for cross-domain sync.
- `full`  out  1  FIFO full, registered.
- `almost_full`  out  1  level ≥ AFULL_THRESH, registered.
- `wlevel`  out  PTR_WIDTH+1  write-side view of the fill level, 0 .. 2^PTR_WIDTH.
- `overflow`  out  1  sticky: a write was attempted while `full`.

## Operation
- Accepted write: `w_acc = w_en & !full`. RAM write enable is `w_acc` (generated by the top level from the same terms).
- `b_wptr_next = b_wptr + w_acc`, modulo 2^(PTR_WIDTH+1).
- `g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next`.
- Full compare: `full_next = (g_wptr_next == {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]})`.
- Level:
  - `b_rptr_sync` is the Gray-to-binary conversion of `g_rptr_sync` (XOR prefix from the MSB).
  - `wlevel_next = b_wptr_next - b_rptr_sync`, modulo 2^(PTR_WIDTH+1); never exceeds 2^PTR_WIDTH.
- `almost_full_next = (wlevel_next >= AFULL_THRESH)`.
- Overflow:
  - Set when `w_en & full` at a clock edge; the write is dropped and the pointers hold.
  - Cleared by `ovf_clr`. If set and clear occur in the same cycle, set wins.
- Status is pessimistic: reads become visible only after synchronizer delay, so `full`, `almost_full` and `wlevel` may overstate occupancy. They never understate it.

## Timing
- Reset (`wrst` high, asynchronous): `b_wptr`=0, `g_wptr`=0, `full`=0, `almost_full`=0, `wlevel`=0, `overflow`=0. Release is synchronous to `wclk` at the top level.
- All outputs are registered, with one-cycle latency from the `wclk` edge that samples `w_en` / `g_rptr_sync`.
  - The edge that accepts the 2^PTR_WIDTH-th unread write also sets `full`.
  - `w_en` in the following cycle is rejected.
- A `g_rptr_sync` change clears `full` and updates `wlevel` at the next `wclk` edge.
- Wrap: pointers roll from 2^(PTR_WIDTH+1)-1 to 0 without a glitch. Gray output changes exactly one bit per accepted write.
- Reset asserted mid-burst: all outputs return to reset values immediately. Writes in flight are lost.

## Configuration
- `WPTR_LEVEL_EN` defined:
  - Gray-to-binary converter, `wlevel` and `almost_full` logic are compiled in as described above.
- `WPTR_LEVEL_EN` undefined:
  - Converter, subtractor and threshold compare are absent.
  - `wlevel` and `almost_full` are driven constant 0.
  - `full`, pointers and `overflow` are unchanged.
  - `AFULL_THRESH` is ignored.

## Test plan
All scenarios use PTR_WIDTH=3, AFULL_THRESH=6, with `WPTR_LEVEL_EN` defined unless noted.
- Reset: pulse `wrst` while `w_en`=1 → all outputs 0 during and after reset; `b_wptr` only increments after `wrst` falls.
- Fill: `g_rptr_sync`=4'b0000, 8 consecutive `w_en` → `b_wptr` 1..8, `g_wptr`=4'b1100 and `full`=1 after the 8th edge, `wlevel`=8, `almost_full`=1 from the 6th edge on.
- Overflow: with `full`=1, hold `w_en` for 2 cycles → `b_wptr` stays 8, `overflow`=1. Assert `ovf_clr` together with `w_en` → `overflow` stays 1. Assert `ovf_clr` alone → `overflow`=0.
- Drain view: from full, set `g_rptr_sync`=4'b0010 (binary 3) → next edge `full`=0, `wlevel`=5, `almost_full`=0.
- Wrap: `b_wptr`=15, `g_rptr_sync`=4'b1101 (binary 9), 2 writes → `b_wptr` 0 then 1, `wlevel` 7 then 8, `full`=1 after the second write, `g_wptr`=4'b0001.
- Build without `WPTR_LEVEL_EN`: repeat Fill → identical `full` and pointers; `wlevel` and `almost_full` stay 0.
